// File: rtl/sprite_anim_addr_gen.sv
// Sprite ROM address generator: maps the VGA pixel to a frame-relative ROM address,
// sequences the attack animation on frame_clk edges and aligns hit with ROM output.
module sprite_anim_addr_gen #(
    parameter int FRAME_W    = 20,
    parameter int FRAME_H    = 30,
    parameter int NUM_FRAMES = 4,
    parameter int FRAME_HOLD = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        attack_start,
    input  logic        facing_left,
    input  logic [9:0]  sprite_x,
    input  logic [9:0]  sprite_y,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [4:0]  rom_data,
    output logic [18:0] read_address,
    output logic [4:0]  pixel_idx,
    output logic        pixel_on,
    output logic        busy,
    output logic        attack_done
);

    localparam int FRW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int HDW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam logic [FRW-1:0] LAST_FRAME = FRW'(NUM_FRAMES - 1);
    localparam logic [HDW-1:0] LAST_HOLD  = HDW'(FRAME_HOLD - 1);
    localparam logic [10:0]    FRAME_W11  = 11'(FRAME_W);
    localparam logic [10:0]    FRAME_H11  = 11'(FRAME_H);
    localparam logic [9:0]     COL_MAX    = 10'(FRAME_W - 1);
    localparam logic [18:0]    FRAME_W19  = 19'(FRAME_W);
    localparam logic [18:0]    FRAME_SZ19 = 19'(FRAME_W * FRAME_H);

    typedef enum logic [1:0] {IDLE, ATTACK, DONE} state_t;

    state_t         state, state_n;
    logic [FRW-1:0] frame, frame_n;
    logic [HDW-1:0] hold_cnt, hold_n;
    logic           fc_prev, fc_rise;

    logic [10:0] x_end, y_end;
    logic        hit, hit_d1, hit_d2;
    logic [9:0]  dx, dy, col;
    logic [18:0] addr_n;

    assign fc_rise = frame_clk & ~fc_prev;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            frame    <= '0;
            hold_cnt <= '0;
            fc_prev  <= 1'b0;
        end else begin
            state    <= state_n;
            frame    <= frame_n;
            hold_cnt <= hold_n;
            fc_prev  <= frame_clk;
        end
    end

    always_comb begin
        state_n = state;
        frame_n = frame;
        hold_n  = hold_cnt;
        case (state)
            IDLE: begin
                frame_n = '0;
                hold_n  = '0;
                if (attack_start) state_n = ATTACK;
            end
            ATTACK: begin
                if (fc_rise) begin
                    if (hold_cnt == LAST_HOLD) begin
                        hold_n = '0;
                        if (frame == LAST_FRAME) state_n = DONE;
                        else                     frame_n = frame + 1'b1;
                    end else begin
                        hold_n = hold_cnt + 1'b1;
                    end
                end
            end
            DONE: begin
                frame_n = '0;
                hold_n  = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy        = (state == ATTACK);
    assign attack_done = (state == DONE);

    // Bounds are checked at 11 bits before any subtraction, so sprites near
    // the screen edge never alias through unsigned wrap.
    assign x_end = {1'b0, sprite_x} + FRAME_W11;
    assign y_end = {1'b0, sprite_y} + FRAME_H11;
    assign hit   = (DrawX >= sprite_x) && ({1'b0, DrawX} < x_end) &&
                   (DrawY >= sprite_y) && ({1'b0, DrawY} < y_end);

    assign dx     = DrawX - sprite_x;
    assign dy     = DrawY - sprite_y;
    assign col    = facing_left ? (COL_MAX - dx) : dx;
    assign addr_n = 19'(frame) * FRAME_SZ19 + 19'(dy) * FRAME_W19 + 19'(col);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            read_address <= '0;
            hit_d1       <= 1'b0;
            hit_d2       <= 1'b0;
        end else begin
            read_address <= hit ? addr_n : '0;
            hit_d1       <= hit;
            hit_d2       <= hit_d1;
        end
    end

    // Palette index 0 is the transparent colour.
    assign pixel_idx = hit_d2 ? rom_data : '0;
    assign pixel_on  = hit_d2 && (rom_data != '0);

endmodule

// File: tb/tb_sprite_anim_addr_gen.sv
// Bench for sprite_anim_addr_gen: directed pixel vectors feed an expected queue,
// a negedge monitor compares address and pixel outputs as the pipeline delivers them.
module tb_sprite_anim_addr_gen;

    logic        clk = 1'b0;
    logic        Reset, frame_clk, attack_start, facing_left;
    logic [9:0]  sprite_x, sprite_y, DrawX, DrawY;
    logic [4:0]  rom_data;
    logic [18:0] read_address;
    logic [4:0]  pixel_idx;
    logic        pixel_on, busy, attack_done;

    int checks = 0;
    int passes = 0;

    logic [18:0] exp_addr_q[$];
    logic [5:0]  exp_pix_q[$];
    logic        stim_v = 1'b0, v_d1 = 1'b0, v_d2 = 1'b0;
    logic [18:0] ae;
    logic [5:0]  pe;

    always #5 clk = ~clk;

    sprite_anim_addr_gen dut (
        .Clk(clk), .Reset(Reset), .frame_clk(frame_clk), .attack_start(attack_start),
        .facing_left(facing_left), .sprite_x(sprite_x), .sprite_y(sprite_y),
        .DrawX(DrawX), .DrawY(DrawY), .rom_data(rom_data), .read_address(read_address),
        .pixel_idx(pixel_idx), .pixel_on(pixel_on), .busy(busy), .attack_done(attack_done)
    );

    function automatic logic [4:0] rom_f(input logic [18:0] a);
        return a[4:0] ^ 5'd5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_px(input logic [9:0] x, input logic [9:0] y, input logic fl,
                            input logic exp_hit, input logic [18:0] exp_a);
        logic [4:0] idx;
        DrawX       = x;
        DrawY       = y;
        facing_left = fl;
        stim_v      = 1'b1;
        idx = exp_hit ? rom_f(exp_a) : 5'd0;
        exp_addr_q.push_back(exp_hit ? exp_a : 19'd0);
        exp_pix_q.push_back({idx != 5'd0, idx});
        tick();
        stim_v = 1'b0;
    endtask

    task automatic fc_pulse(input int high_cycles);
        frame_clk = 1'b1;
        repeat (high_cycles) tick();
        frame_clk = 1'b0;
        repeat (2) tick();
    endtask

    task automatic pulse_attack();
        attack_start = 1'b1;
        tick();
        attack_start = 1'b0;
    endtask

    // Registered ROM model plus the tb-side valid pipeline.
    always @(posedge clk) begin
        rom_data <= rom_f(read_address);
        v_d1     <= stim_v;
        v_d2     <= v_d1;
    end

    always @(negedge clk) begin
        if (v_d1) begin
            if (exp_addr_q.size() == 0) check("addr_q_underflow", 32'd1, 32'd0);
            else begin
                ae = exp_addr_q.pop_front();
                check("read_address", 32'(read_address), 32'(ae));
            end
        end
        if (v_d2) begin
            if (exp_pix_q.size() == 0) check("pix_q_underflow", 32'd1, 32'd0);
            else begin
                pe = exp_pix_q.pop_front();
                check("pixel_on", 32'(pixel_on), 32'(pe[5]));
                check("pixel_idx", 32'(pixel_idx), 32'(pe[4:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1; frame_clk = 1'b0; attack_start = 1'b0; facing_left = 1'b0;
        sprite_x = 10'd100; sprite_y = 10'd200; DrawX = 10'd100; DrawY = 10'd200;
        repeat (3) tick();
        @(negedge clk);
        check("rst_read_address", 32'(read_address), 32'd0);
        check("rst_pixel_on", 32'(pixel_on), 32'd0);
        check("rst_pixel_idx", 32'(pixel_idx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_attack_done", 32'(attack_done), 32'd0);
        tick();
        Reset = 1'b0;
        tick();

        // Window, bounds, transparency and mirror vectors in idle (frame 0).
        drive_px(10'd100, 10'd200, 1'b0, 1'b1, 19'd0);
        drive_px(10'd119, 10'd229, 1'b0, 1'b1, 19'd599);
        drive_px(10'd120, 10'd229, 1'b0, 1'b0, 19'd0);
        drive_px(10'd119, 10'd230, 1'b0, 1'b0, 19'd0);
        drive_px(10'd99,  10'd200, 1'b0, 1'b0, 19'd0);
        drive_px(10'd105, 10'd200, 1'b0, 1'b1, 19'd5);
        drive_px(10'd110, 10'd215, 1'b0, 1'b1, 19'd310);
        drive_px(10'd100, 10'd201, 1'b1, 1'b1, 19'd39);
        drive_px(10'd119, 10'd201, 1'b1, 1'b1, 19'd20);
        drive_px(10'd100, 10'd199, 1'b1, 1'b0, 19'd0);
        sprite_x = 10'd1010; sprite_y = 10'd0;
        drive_px(10'd1023, 10'd0, 1'b0, 1'b1, 19'd13);
        drive_px(10'd1009, 10'd0, 1'b0, 1'b0, 19'd0);
        drive_px(10'd1023, 10'd30, 1'b0, 1'b0, 19'd0);
        sprite_x = 10'd100; sprite_y = 10'd200;
        repeat (3) tick();

        // Full attack animation.
        pulse_attack();
        @(negedge clk);
        check("busy_start", 32'(busy), 32'd1);
        tick();
        repeat (4) fc_pulse(2);
        drive_px(10'd100, 10'd200, 1'b0, 1'b1, 19'd600);
        pulse_attack();
        repeat (4) fc_pulse(2);
        drive_px(10'd100, 10'd200, 1'b0, 1'b1, 19'd1200);
        drive_px(10'd119, 10'd229, 1'b0, 1'b1, 19'd1799);
        repeat (3) fc_pulse(2);
        fc_pulse(10);
        repeat (3) fc_pulse(2);
        drive_px(10'd100, 10'd200, 1'b0, 1'b1, 19'd1800);
        @(negedge clk);
        check("busy_frame3", 32'(busy), 32'd1);
        tick();
        frame_clk = 1'b1;
        tick();
        @(negedge clk);
        check("done_pulse", 32'(attack_done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        tick();
        @(negedge clk);
        check("done_cleared", 32'(attack_done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        tick();
        frame_clk = 1'b0;
        tick();
        drive_px(10'd100, 10'd200, 1'b0, 1'b1, 19'd0);
        repeat (3) tick();

        // Reset while in frame 2 of a new attack.
        pulse_attack();
        repeat (8) fc_pulse(2);
        drive_px(10'd100, 10'd200, 1'b0, 1'b1, 19'd1200);
        repeat (3) tick();
        Reset = 1'b1;
        attack_start = 1'b1;
        tick();
        @(negedge clk);
        check("midrst_read_address", 32'(read_address), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_attack_done", 32'(attack_done), 32'd0);
        check("midrst_pixel_on", 32'(pixel_on), 32'd0);
        check("midrst_pixel_idx", 32'(pixel_idx), 32'd0);
        tick();
        Reset = 1'b0;
        attack_start = 1'b0;
        tick();
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        tick();
        drive_px(10'd100, 10'd200, 1'b0, 1'b1, 19'd0);
        drive_px(10'd119, 10'd229, 1'b0, 1'b1, 19'd599);

        repeat (4) tick();
        check("queues_drained", 32'(exp_addr_q.size() + exp_pix_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sprite_anim_addr_gen.md
Name: sprite_anim_addr_gen

Overview:
- Upstream address stage for the 5-bit palette-index sprite ROMs (2400 x 5 bit, 1-cycle registered read).
- Maps the current VGA pixel (DrawX/DrawY) and sprite position to a ROM read_address.
- Sequences a multi-frame attack animation, paced by frame_clk.
- Aligns the ROM output with a hit flag and emits a transparent-aware pixel_idx/pixel_on pair to the color mapper.

Parameters:
- FRAME_W, 20, sprite frame width in pixels
- FRAME_H, 30, sprite frame height in pixels
- NUM_FRAMES, 4, animation frames stored back to back in ROM (FRAME_W*FRAME_H*NUM_FRAMES = 2400)
- FRAME_HOLD, 4, frame_clk rising edges each animation frame is shown

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- frame_clk  in  1  vsync-rate level signal; rising edge detected internally
- attack_start  in  1  single-cycle request to play the attack animation
- facing_left  in  1  1 = horizontally mirror the sprite
- sprite_x  in  10  left column of sprite on screen
- sprite_y  in  10  top row of sprite on screen
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- rom_data  in  5  palette index from ROM, valid 1 cycle after read_address
- read_address  out  19  ROM address
- pixel_idx  out  5  palette index to color mapper
- pixel_on  out  1  sprite pixel is opaque at current (delayed) pixel
- busy  out  1  animation in progress
- attack_done  out  1  one-cycle pulse at end of animation

Behaviour:
- Reset (synchronous, active-high) clears all registers:
  - read_address=0, hit pipeline=0, pixel_on=0, pixel_idx=0, busy=0, attack_done=0.
  - frame=0, hold_cnt=0, fc_prev=0, state=IDLE.
  - Reset overrides all other inputs, including during ATTACK.
- Edge detect: fc_prev<=frame_clk each cycle; fc_rise = frame_clk & ~fc_prev.
- FSM states: IDLE, ATTACK, DONE.
  - IDLE: frame=0, busy=0. attack_start -> ATTACK with frame=0, hold_cnt=0.
  - ATTACK: busy=1; attack_start is ignored. On fc_rise:
    - if hold_cnt==FRAME_HOLD-1, then hold_cnt<=0; if frame==NUM_FRAMES-1 go DONE, else frame<=frame+1.
    - otherwise hold_cnt<=hold_cnt+1.
  - DONE: lasts exactly one cycle. attack_done=1, busy=0, frame<=0, next state IDLE. attack_start in DONE is ignored.
- Hit test: compare before subtracting, so unsigned wrap cannot occur.
  - hit = (DrawX>=sprite_x) && (DrawX<sprite_x+FRAME_W) && (DrawY>=sprite_y) && (DrawY<sprite_y+FRAME_H).
  - Sums are computed at 11 bits.
- Column select: dx=DrawX-sprite_x, dy=DrawY-sprite_y; col = facing_left ? FRAME_W-1-dx : dx.
- Address: frame*FRAME_W*FRAME_H + dy*FRAME_W + col, zero-extended to 19 bits.
  - Registered: read_address and hit_d1 update on the same edge, 1 cycle after DrawX/DrawY.
  - When hit=0, read_address<=0.
- Stage 2: hit_d2<=hit_d1, aligned with rom_data.
  - pixel_on = hit_d2 && (rom_data!=0); index 0 is transparent.
  - pixel_idx = hit_d2 ? rom_data : 0, combinational from hit_d2 and rom_data.
- Total latency from DrawX/DrawY to pixel_on/pixel_idx: 2 Clk cycles.
- Animation frame changes take effect on the address computed in the cycle after frame updates; no mid-line protection is required.

Test Plan:
- Basic address and latency: idle, sprite_x=100, sprite_y=200, DrawX=100, DrawY=200 -> read_address=0 after 1 cycle. With ROM model returning 5, pixel_on=1 and pixel_idx=5 two cycles after stimulus.
- Window bounds:
  - DrawX=119, DrawY=229 -> read_address=599, pixel_on follows rom_data.
  - DrawX=120 or DrawY=230 -> hit 0, pixel_on=0, pixel_idx=0.
  - DrawX=99 -> pixel_on=0 (no unsigned wrap).
- Transparency and mirror:
  - rom_data=0 inside window -> pixel_on=0.
  - facing_left=1, DrawX=100, DrawY=201 -> read_address=20+19=39.
- Animation sequence: pulse attack_start, busy=1 next cycle.
  - After 4 fc_rise, DrawX=100, DrawY=200 -> read_address=600.
  - After 16 fc_rise, attack_done high exactly 1 cycle, busy=0, address back to 0.
  - A second attack_start mid-animation does not restart the frame count.
- Edge detect: hold frame_clk high for 10 cycles -> counts as one edge only.
- Reset mid-operation: assert Reset during frame 2 -> next cycle state IDLE, busy=0, all outputs 0. After release, DrawX=100, DrawY=200 -> read_address=0.
